// File: rtl/adder_share_arbiter_if.sv
// Bundles the requester and response handshakes of the shared-adder arbiter.
// The master side drives requests and consumes responses; the slave side is the arbiter.
interface adder_share_arbiter_if #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// One Kogge-Stone adder shared by NREQ requesters through a round-robin arbiter.
// The granted operand pair is summed and captured into a single registered response slot.
module adder #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] hs;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    logic [WIDTH-1:0] c;

    always_comb begin
        hs = a ^ b;
        g  = a & b;
        p  = hs;
        gn = g;
        pn = p;
        // Each level doubles the span of the group generate/propagate terms.
        for (int l = 0; l < LVL; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
                pn[i] = p[i] & p[i-(1<<l)];
            end
            g = gn;
            p = pn;
        end
        c = '0;
        for (int i = 1; i < WIDTH; i++) begin
            c[i] = g[i-1];
        end
        sum  = hs ^ c;
        cout = g[WIDTH-1];
    end
endmodule

module adder_share_arbiter #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    adder_share_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_id_p0;
    logic             gnt_found_p0;
    logic             slot_free_p0;
    logic             accept_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] sum_p0;
    logic             cout_p0;

    logic             vld_p1;
    logic [IDW-1:0]   id_p1;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        if (id == IDW'(NREQ - 1)) return '0;
        return id + IDW'(1);
    endfunction

    // Stage p0: round-robin search starting at rr_ptr, operand mux, shared adder
    always_comb begin
        int idx;
        idx          = 0;
        gnt_found_p0 = 1'b0;
        gnt_id_p0    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found_p0 && bus.req_valid[idx]) begin
                gnt_found_p0 = 1'b1;
                gnt_id_p0    = IDW'(idx);
            end
        end
    end

    assign slot_free_p0  = !vld_p1 || bus.rsp_ready;
    assign accept_p0     = gnt_found_p0 && slot_free_p0;
    assign bus.req_ready = accept_p0 ? (NREQ'(1) << gnt_id_p0) : '0;
    assign a_p0          = bus.req_a[int'(gnt_id_p0)*WIDTH +: WIDTH];
    assign b_p0          = bus.req_b[int'(gnt_id_p0)*WIDTH +: WIDTH];

    adder #(.WIDTH(WIDTH)) u_adder (
        .a    (a_p0),
        .b    (b_p0),
        .sum  (sum_p0),
        .cout (cout_p0)
    );

    // Stage p1: response slot; a drain with a fresh grant overwrites in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            rr_ptr  <= '0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            id_p1   <= gnt_id_p0;
            sum_p1  <= sum_p0;
            cout_p1 <= cout_p0;
            rr_ptr  <= next_ptr(gnt_id_p0);
        end else if (bus.rsp_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.rsp_valid = vld_p1;
    assign bus.rsp_id    = id_p1;
    assign bus.rsp_sum   = sum_p1;
    assign bus.rsp_cout  = cout_p1;
endmodule
